// File: rtl/network_node_pkg.sv
// Shared types and saturation helpers for the ADPLL network-node control core.
`timescale 1ns/1ps
package network_node_pkg;

  localparam logic [1:0] MODE_CLOSED = 2'b00;
  localparam logic [1:0] MODE_HOLD   = 2'b01;
  localparam logic [1:0] MODE_MANUAL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FILTER,
    ST_OUTPUT
  } state_t;

  // Saturate a 64-bit signed value to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

  function automatic logic signed [63:0] sat_EW(input logic signed [63:0] x, input int w);
    return sat_s(x, w);
  endfunction

  function automatic logic signed [63:0] sat_INT(input logic signed [63:0] x, input int w);
    return sat_s(x, w);
  endfunction

  function automatic logic signed [63:0] sat_CC(input logic signed [63:0] x, input int w);
    return sat_s(x, w);
  endfunction

  function automatic logic signed [63:0] clamp_u(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (x < 64'sd0) return 64'sd0;
    else if (x > hi) return hi;
    else return x;
  endfunction

endpackage

// File: rtl/network_node_ctrl_if.sv
// Update request, neighbour data, gains and oscillator-side outputs of one node.
`timescale 1ns/1ps
interface network_node_ctrl_if #(
  parameter int N_PORTS      = 4,
  parameter int ERROR_WIDTH  = 5,
  parameter int WEIGHT_WIDTH = 4,
  parameter int DCO_CC_WIDTH = 5,
  parameter int KP_WIDTH     = 6,
  parameter int KI_WIDTH     = 8
);
  logic                            update_i;
  logic [N_PORTS*ERROR_WIDTH-1:0]  error_i;
  logic [N_PORTS*WEIGHT_WIDTH-1:0] weight_i;
  logic [N_PORTS-1:0]              port_en_i;
  logic [KP_WIDTH-1:0]             kp_i;
  logic [KI_WIDTH-1:0]             ki_i;
  logic [1:0]                      mode_i;
  logic [DCO_CC_WIDTH-1:0]         manual_cc_i;
  logic [DCO_CC_WIDTH-1:0]         dco_cc_o;
  logic [ERROR_WIDTH-1:0]          error_comb_o;
  logic                            valid_o;
  logic                            busy_o;
  logic                            locked_o;
  logic                            overrun_o;

  modport master (
    output update_i, error_i, weight_i, port_en_i, kp_i, ki_i, mode_i, manual_cc_i,
    input  dco_cc_o, error_comb_o, valid_o, busy_o, locked_o, overrun_o
  );

  modport slave (
    input  update_i, error_i, weight_i, port_en_i, kp_i, ki_i, mode_i, manual_cc_i,
    output dco_cc_o, error_comb_o, valid_o, busy_o, locked_o, overrun_o
  );
endinterface

// File: rtl/node_pi_filter.sv
// Saturating PI loop filter: integrator, manual preload and code clamp.
`timescale 1ns/1ps
module node_pi_filter
  import network_node_pkg::*;
#(
  parameter int ERROR_WIDTH   = 5,
  parameter int DCO_CC_WIDTH  = 5,
  parameter int BIAS          = 15,
  parameter int KP_WIDTH      = 6,
  parameter int KP_FRAC_WIDTH = 5,
  parameter int KI_WIDTH      = 8,
  parameter int KI_FRAC_WIDTH = 7,
  parameter int INT_WIDTH     = 20
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_filter,
  input  logic                          i_output,
  input  logic [1:0]                    i_mode,
  input  logic signed [ERROR_WIDTH-1:0] i_e,
  input  logic signed [ERROR_WIDTH-1:0] i_e_q,
  input  logic [KP_WIDTH-1:0]           i_kp,
  input  logic [KI_WIDTH-1:0]           i_ki,
  input  logic [DCO_CC_WIDTH-1:0]       i_manual_cc,
  output logic [DCO_CC_WIDTH-1:0]       o_dco_cc
);
  localparam int GAIN_ALIGN = KI_FRAC_WIDTH - KP_FRAC_WIDTH;
  localparam logic signed [63:0] BIAS64 = 64'(BIAS);
  localparam logic [DCO_CC_WIDTH-1:0] CC_RESET = DCO_CC_WIDTH'(clamp_u(BIAS64, DCO_CC_WIDTH));

  logic signed [INT_WIDTH-1:0] r_integ;
  logic [1:0]                  r_mode;
  logic [DCO_CC_WIDTH-1:0]     r_dco_cc;

  logic signed [63:0]          w_integ64;
  logic signed [63:0]          w_sum;
  logic signed [63:0]          w_lf;
  logic signed [INT_WIDTH-1:0] w_int_closed;
  logic signed [INT_WIDTH-1:0] w_int_manual;
  logic [DCO_CC_WIDTH-1:0]     w_code;

  assign w_integ64    = 64'(r_integ);
  assign w_int_closed = INT_WIDTH'(sat_INT(w_integ64 + 64'(i_e) * $signed(64'(i_ki)), INT_WIDTH));
  // Preloading the integrator with the manual code's offset lets closed mode resume without a step.
  assign w_int_manual = INT_WIDTH'(sat_INT((BIAS64 - $signed(64'(i_manual_cc))) <<< KI_FRAC_WIDTH,
                                           INT_WIDTH));
  assign w_sum  = w_integ64 + ((64'(i_e_q) * $signed(64'(i_kp))) <<< GAIN_ALIGN);
  assign w_lf   = sat_CC(w_sum >>> KI_FRAC_WIDTH, DCO_CC_WIDTH);
  assign w_code = DCO_CC_WIDTH'(clamp_u(BIAS64 - w_lf, DCO_CC_WIDTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_integ  <= '0;
      r_mode   <= MODE_CLOSED;
      r_dco_cc <= CC_RESET;
    end else begin
      if (i_filter) begin
        r_mode <= i_mode;
        case (i_mode)
          MODE_CLOSED: r_integ <= w_int_closed;
          MODE_MANUAL: r_integ <= w_int_manual;
          default:     r_integ <= r_integ;
        endcase
      end
      if (i_output) begin
        case (r_mode)
          MODE_CLOSED: r_dco_cc <= w_code;
          MODE_MANUAL: r_dco_cc <= i_manual_cc;
          default:     r_dco_cc <= r_dco_cc;
        endcase
      end
    end
  end

  assign o_dco_cc = r_dco_cc;

endmodule

// File: rtl/network_node_ctrl.sv
// ADPLL node control core: serial weighted combiner, PI filter, lock and overrun tracking.
//   state     | meaning
//   ST_IDLE   | waiting for update_i
//   ST_ACCUM  | one weighted port error added per cycle
//   ST_FILTER | combined error registered, integrator updated
//   ST_OUTPUT | code, lock and valid registered
`timescale 1ns/1ps
module network_node_ctrl
  import network_node_pkg::*;
#(
  parameter int N_PORTS       = 4,
  parameter int ERROR_WIDTH   = 5,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int COMB_SHIFT    = 3,
  parameter int DCO_CC_WIDTH  = 5,
  parameter int BIAS          = 15,
  parameter int KP_WIDTH      = 6,
  parameter int KP_FRAC_WIDTH = 5,
  parameter int KI_WIDTH      = 8,
  parameter int KI_FRAC_WIDTH = 7,
  parameter int INT_WIDTH     = 20,
  parameter int LOCK_THRESH   = 1,
  parameter int LOCK_COUNT    = 16
) (
  input logic                fpga_clk_i,
  input logic                reset_n_i,
  network_node_ctrl_if.slave bus
);
  localparam int ACC_W = ERROR_WIDTH + WEIGHT_WIDTH + $clog2(N_PORTS) + 1;
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  logic [1:0]                      r_rst_sync;
  logic                            w_rst_n;
  state_t                          r_state;
  logic [IDX_W-1:0]                r_idx;
  logic signed [ACC_W-1:0]         r_acc;
  logic [N_PORTS*ERROR_WIDTH-1:0]  r_err;
  logic [N_PORTS*WEIGHT_WIDTH-1:0] r_wgt;
  logic [N_PORTS-1:0]              r_en;
  logic signed [ERROR_WIDTH-1:0]   r_err_comb;
  logic                            r_valid;
  logic                            r_busy;
  logic [CNT_W-1:0]                r_lock_cnt;
  logic                            r_locked;
  logic                            r_overrun;

  logic signed [ERROR_WIDTH-1:0]   w_err_k;
  logic [WEIGHT_WIDTH-1:0]         w_wgt_k;
  logic signed [ACC_W-1:0]         w_contrib;
  logic signed [63:0]              w_acc64;
  logic signed [ERROR_WIDTH-1:0]   w_e;
  logic signed [63:0]              w_e_q64;
  logic                            w_in_lock;
  logic [DCO_CC_WIDTH-1:0]         w_dco_cc;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_err_k   = r_err[int'(r_idx)*ERROR_WIDTH +: ERROR_WIDTH];
  assign w_wgt_k   = r_wgt[int'(r_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign w_contrib = r_en[r_idx] ? ACC_W'(w_err_k) * ACC_W'($signed({1'b0, w_wgt_k})) : '0;
  assign w_acc64   = 64'(r_acc);
  assign w_e       = ERROR_WIDTH'(sat_EW(w_acc64 >>> COMB_SHIFT, ERROR_WIDTH));
  assign w_e_q64   = 64'(r_err_comb);
  assign w_in_lock = (w_e_q64 <= 64'(LOCK_THRESH)) && (w_e_q64 >= -64'(LOCK_THRESH));

  always_ff @(posedge fpga_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_acc      <= '0;
      r_err      <= '0;
      r_wgt      <= '0;
      r_en       <= '0;
      r_err_comb <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.update_i && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (bus.update_i) begin
            r_acc   <= '0;
            r_err   <= bus.error_i;
            r_wgt   <= bus.weight_i;
            r_en    <= bus.port_en_i;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc <= r_acc + w_contrib;
          if (r_idx == IDX_W'(N_PORTS - 1)) r_state <= ST_FILTER;
          else                              r_idx   <= r_idx + IDX_W'(1);
        end
        ST_FILTER: begin
          r_err_comb <= w_e;
          r_state    <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (w_in_lock) begin
            if (r_lock_cnt != CNT_W'(LOCK_COUNT)) r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            r_locked <= (r_lock_cnt >= CNT_W'(LOCK_COUNT - 1));
          end else begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
          end
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  node_pi_filter #(
    .ERROR_WIDTH  (ERROR_WIDTH),
    .DCO_CC_WIDTH (DCO_CC_WIDTH),
    .BIAS         (BIAS),
    .KP_WIDTH     (KP_WIDTH),
    .KP_FRAC_WIDTH(KP_FRAC_WIDTH),
    .KI_WIDTH     (KI_WIDTH),
    .KI_FRAC_WIDTH(KI_FRAC_WIDTH),
    .INT_WIDTH    (INT_WIDTH)
  ) u_pi_filter (
    .i_clk      (fpga_clk_i),
    .i_rst_n    (w_rst_n),
    .i_filter   (r_state == ST_FILTER),
    .i_output   (r_state == ST_OUTPUT),
    .i_mode     (bus.mode_i),
    .i_e        (w_e),
    .i_e_q      (r_err_comb),
    .i_kp       (bus.kp_i),
    .i_ki       (bus.ki_i),
    .i_manual_cc(bus.manual_cc_i),
    .o_dco_cc   (w_dco_cc)
  );

  assign bus.dco_cc_o     = w_dco_cc;
  assign bus.error_comb_o = r_err_comb;
  assign bus.valid_o      = r_valid;
  assign bus.busy_o       = r_busy;
  assign bus.locked_o     = r_locked;
  assign bus.overrun_o    = r_overrun;

endmodule

// File: tb/tb_network_node_ctrl.sv
// Scoreboard bench for network_node_ctrl with an integer reference model of the loop.
`timescale 1ns/1ps
module tb_network_node_ctrl;

  localparam int  N  = 4;
  localparam longint KP = 9;
  localparam longint KI = 1;

  typedef struct {
    longint e;
    longint dco;
    longint locked;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  longint m_integ, m_dco, m_cnt, m_locked;

  network_node_ctrl_if #(.N_PORTS(N)) bus ();

  network_node_ctrl dut (
    .fpga_clk_i(clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input longint expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic longint clip(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic logic [19:0] rep_err(input int v);
    logic [19:0] r;
    for (int k = 0; k < N; k++) r[k*5 +: 5] = 5'(v);
    return r;
  endfunction

  function automatic logic [15:0] rep_w(input int v);
    logic [15:0] r;
    for (int k = 0; k < N; k++) r[k*4 +: 4] = 4'(v);
    return r;
  endfunction

  task automatic model_reset();
    m_integ = 0; m_dco = 15; m_cnt = 0; m_locked = 0;
  endtask

  task automatic model_push(input logic [19:0] ep, input logic [15:0] wp, input logic [3:0] en,
                            input logic [1:0] md, input logic [4:0] man);
    longint acc, e, lf;
    exp_t x;
    acc = 0;
    for (int k = 0; k < N; k++)
      if (en[k]) acc += longint'($signed(ep[k*5 +: 5])) * longint'(wp[k*4 +: 4]);
    e = clip(floor_div(acc, 8), -16, 15);
    if (md == 2'b00) begin
      m_integ = clip(m_integ + e * KI, -524288, 524287);
      lf = clip(floor_div(m_integ + e * KP * 4, 128), -16, 15);
      m_dco = clip(15 - lf, 0, 31);
    end else if (md == 2'b10) begin
      m_integ = (15 - longint'(man)) * 128;
      m_dco = longint'(man);
    end
    if (e >= -1 && e <= 1) begin
      if (m_cnt < 16) m_cnt++;
      m_locked = (m_cnt == 16) ? 1 : 0;
    end else begin
      m_cnt = 0;
      m_locked = 0;
    end
    x.e = e; x.dco = m_dco; x.locked = m_locked;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // glitch > 0 pulses update_i again so it is sampled at edge E<glitch> of this update.
  task automatic run_update(input logic [19:0] ep, input logic [15:0] wp, input logic [3:0] en,
                            input logic [1:0] md, input logic [4:0] man, input int glitch);
    int lat;
    model_push(ep, wp, en, md, man);
    @(negedge clk);
    bus.error_i = ep; bus.weight_i = wp; bus.port_en_i = en;
    bus.mode_i = md; bus.manual_cc_i = man; bus.update_i = 1'b1;
    @(posedge clk); #1;
    bus.update_i = 1'b0;
    chk("busy_after_e0", bus.busy_o, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == glitch) bus.update_i = 1'b1;
      @(posedge clk); #1;
      bus.update_i = 1'b0;
      if (bus.valid_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("valid_latency", lat, N + 2);
    chk("busy_after_output", bus.busy_o, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("error_comb", $signed(bus.error_comb_o), x.e);
        chk("dco_cc", bus.dco_cc_o, x.dco);
        chk("locked", bus.locked_o, x.locked);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.update_i = 1'b0; bus.error_i = '0; bus.weight_i = '0; bus.port_en_i = '0;
    bus.kp_i = 6'd9; bus.ki_i = 8'd1; bus.mode_i = 2'b00; bus.manual_cc_i = '0;
    do_reset();
    chk("rst_dco", bus.dco_cc_o, 15);
    chk("rst_locked", bus.locked_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_overrun", bus.overrun_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_error_comb", bus.error_comb_o, 0);

    run_update(rep_err(4), rep_w(2), 4'hF, 2'b00, 5'd0, 0);
    chk("basic_error_comb", $signed(bus.error_comb_o), 4);
    chk("basic_dco", bus.dco_cc_o, 14);

    run_update(rep_err(4), rep_w(2), 4'b0001, 2'b00, 5'd0, 0);

    for (int i = 0; i < 90; i++) run_update(rep_err(-16), rep_w(15), 4'hF, 2'b00, 5'd0, 0);
    chk("sat_error_comb", $signed(bus.error_comb_o), -16);
    chk("sat_dco_clamp", bus.dco_cc_o, 31);

    for (int i = 0; i < 6; i++)
      run_update(20'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 2'b00, 5'd0, 0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_update(rep_err(0), rep_w(3), 4'hF, 2'b00, 5'd0, 0);
      chk("lock_rise", bus.locked_o, (i == 15) ? 1 : 0);
    end
    run_update(rep_err(2), rep_w(2), 4'hF, 2'b00, 5'd0, 0);
    chk("lock_drop", bus.locked_o, 0);

    run_update(rep_err(0), rep_w(1), 4'hF, 2'b10, 5'd10, 0);
    chk("manual_dco", bus.dco_cc_o, 10);
    run_update(rep_err(0), rep_w(1), 4'hF, 2'b00, 5'd0, 0);
    chk("bumpless_dco", bus.dco_cc_o, 10);
    run_update(rep_err(4), rep_w(2), 4'hF, 2'b01, 5'd3, 0);
    chk("hold_dco", bus.dco_cc_o, 10);
    run_update(rep_err(-8), rep_w(2), 4'hF, 2'b11, 5'd3, 0);
    chk("hold11_dco", bus.dco_cc_o, 10);
    chk("hold11_error_comb", $signed(bus.error_comb_o), -8);

    chk("overrun_before", bus.overrun_o, 0);
    run_update(rep_err(1), rep_w(8), 4'hF, 2'b00, 5'd0, 2);
    chk("overrun_set", bus.overrun_o, 1);
    repeat (10) @(negedge clk);
    chk("overrun_sticky", bus.overrun_o, 1);

    @(negedge clk);
    bus.error_i = rep_err(5); bus.weight_i = rep_w(7); bus.port_en_i = 4'hF;
    bus.mode_i = 2'b00; bus.update_i = 1'b1;
    @(posedge clk); #1;
    bus.update_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_valid", bus.valid_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_dco", bus.dco_cc_o, 15);
    chk("abort_overrun", bus.overrun_o, 0);
    chk("abort_busy_after", bus.busy_o, 0);

    repeat (3) @(negedge clk);
    chk("pending_expect", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
